// File: rtl/fc_mover_pkg.sv
// fc_mover_pkg: shared FSM encoding, datapath widths and small helpers for the FC data mover
package fc_mover_pkg;

    typedef enum logic [2:0] {IDLE, BIAS, RUN, FLUSH, WRITE, DONE} state_t;

    localparam int ELEM_PER_WORD = 32 / 8;
    localparam int PROD_WIDTH    = 2 * 8 + 2;

    function automatic int prod_width(input int iw);
        return 2 * iw + 2;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// fc_mac_lane: one MAC lane - packed element multiply, registered sum, wrapping accumulator, ReLU output
module fc_mac_lane
    import fc_mover_pkg::*;
#(
    parameter int DWIDTH        = 32,
    parameter int IN_DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_bias,
    input  logic              acc_en,
    input  logic              is_signed,
    input  logic              relu,
    input  logic [DWIDTH-1:0] node,
    input  logic [DWIDTH-1:0] wgt,
    input  logic [DWIDTH-1:0] bias,
    output logic [DWIDTH-1:0] result
);
    localparam int EPW = DWIDTH / IN_DATA_WIDTH;
    localparam int PW  = prod_width(IN_DATA_WIDTH);

    logic signed [IN_DATA_WIDTH:0] a [EPW];
    logic signed [IN_DATA_WIDTH:0] b [EPW];
    logic signed [PW-1:0]          sum_c, sum_q;
    logic        [DWIDTH-1:0]      acc;

    // one extra sign/zero bit per element lets a single signed multiplier serve both modes
    always_comb begin
        sum_c = '0;
        for (int e = 0; e < EPW; e++) begin
            a[e]  = {is_signed & node[DWIDTH-1-e*IN_DATA_WIDTH], node[DWIDTH-1-e*IN_DATA_WIDTH -: IN_DATA_WIDTH]};
            b[e]  = {is_signed & wgt[DWIDTH-1-e*IN_DATA_WIDTH], wgt[DWIDTH-1-e*IN_DATA_WIDTH -: IN_DATA_WIDTH]};
            sum_c = sum_c + a[e] * b[e];
        end
    end

    // product-sum register, then bias seed or wrapping accumulate
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
            acc   <= '0;
        end else begin
            sum_q <= sum_c;
            if (load_bias)
                acc <= bias;
            else if (acc_en)
                acc <= acc + {{(DWIDTH-PW){is_signed & sum_q[PW-1]}}, sum_q};
        end
    end

    assign result = (relu && is_signed && acc[DWIDTH-1]) ? '0 : acc;

endmodule

// File: rtl/fc_data_mover.sv
// fc_data_mover: FC-layer engine streaming node/weight BRAMs through NUM_CORE MAC lanes with bias seed and write-back
module fc_data_mover
    import fc_mover_pkg::*;
#(
    parameter int CNT_BIT       = 31,
    parameter int DWIDTH        = 32,
    parameter int AWIDTH        = 12,
    parameter int MEM_SIZE      = 4096,
    parameter int IN_DATA_WIDTH = 8,
    parameter int NUM_CORE      = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_run,
    input  logic [CNT_BIT-1:0]         i_num_cnt,
    input  logic                       i_signed,
    input  logic                       i_relu,
    output logic                       o_idle,
    output logic                       o_read,
    output logic                       o_write,
    output logic                       o_done,
    output logic [AWIDTH-1:0]          addr_node,
    output logic                       ce_node,
    input  logic [DWIDTH-1:0]          q_node,
    output logic [AWIDTH-1:0]          addr_wgt,
    output logic                       ce_wgt,
    input  logic [NUM_CORE*DWIDTH-1:0] q_wgt,
    output logic [AWIDTH-1:0]          addr_bias,
    output logic                       ce_bias,
    input  logic [NUM_CORE*DWIDTH-1:0] q_bias,
    output logic [AWIDTH-1:0]          addr_res,
    output logic                       ce_res,
    output logic                       we_res,
    output logic [DWIDTH-1:0]          d_res,
    output logic [NUM_CORE*DWIDTH-1:0] o_result
);
    localparam int CW = max2(max2($clog2(MEM_SIZE + 1), AWIDTH), 8);
    localparam int LW = (NUM_CORE > 1) ? $clog2(NUM_CORE) : 1;

    state_t                      state, nxt;
    logic [CW-1:0]               cnt, n_q, n_clamp;
    logic                        sgn_q, relu_q, bias_v, rd_v, prod_v;
    logic [DWIDTH-1:0]           lane_res [NUM_CORE];
    logic [NUM_CORE*DWIDTH-1:0]  res_all;

    assign n_clamp = (i_num_cnt > CNT_BIT'(MEM_SIZE)) ? CW'(MEM_SIZE) : CW'(i_num_cnt);

    // next state plus BRAM strobes/addresses decoded from the current phase and its cycle counter
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = i_run ? BIAS : IDLE;
            BIAS:    nxt = (n_q == '0) ? FLUSH : RUN;
            RUN:     nxt = (cnt == n_q - CW'(1)) ? FLUSH : RUN;
            FLUSH:   nxt = (cnt == CW'(1)) ? WRITE : FLUSH;
            WRITE:   nxt = (cnt == CW'(NUM_CORE - 1)) ? DONE : WRITE;
            default: nxt = IDLE;
        endcase
        ce_node   = state == RUN;
        ce_wgt    = ce_node;
        addr_node = ce_node ? cnt[AWIDTH-1:0] : '0;
        addr_wgt  = addr_node;
        ce_bias   = state == BIAS;
        addr_bias = '0;
        ce_res    = state == WRITE;
        we_res    = ce_res;
        addr_res  = ce_res ? cnt[AWIDTH-1:0] : '0;
        d_res     = ce_res ? lane_res[cnt[LW-1:0]] : '0;
    end

    // state register; cnt restarts on every phase change so it indexes words, flush slots and lanes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= nxt;
            cnt   <= (nxt != state) ? '0 : cnt + CW'(1);
        end
    end

    // run context captured at start, and valid pipeline matching BRAM latency and the sum register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q    <= '0;
            sgn_q  <= 1'b0;
            relu_q <= 1'b0;
            bias_v <= 1'b0;
            rd_v   <= 1'b0;
            prod_v <= 1'b0;
        end else begin
            if (state == IDLE && i_run) begin
                n_q    <= n_clamp;
                sgn_q  <= i_signed;
                relu_q <= i_relu;
            end
            bias_v <= state == BIAS;
            rd_v   <= state == RUN;
            prod_v <= rd_v;
        end
    end

    // registered status flags and the result snapshot taken once all accumulates have landed
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_idle   <= 1'b1;
            o_read   <= 1'b0;
            o_write  <= 1'b0;
            o_done   <= 1'b0;
            o_result <= '0;
        end else begin
            o_idle  <= nxt == IDLE;
            o_read  <= nxt == RUN;
            o_write <= nxt == WRITE;
            o_done  <= nxt == DONE;
            if (state == WRITE && cnt == '0)
                o_result <= res_all;
        end
    end

    for (genvar c = 0; c < NUM_CORE; c++) begin : g_lane
        fc_mac_lane #(
            .DWIDTH        (DWIDTH),
            .IN_DATA_WIDTH (IN_DATA_WIDTH)
        ) u_lane (
            .clk       (clk),
            .reset     (reset),
            .load_bias (bias_v),
            .acc_en    (prod_v),
            .is_signed (sgn_q),
            .relu      (relu_q),
            .node      (q_node),
            .wgt       (q_wgt[c*DWIDTH +: DWIDTH]),
            .bias      (q_bias[c*DWIDTH +: DWIDTH]),
            .result    (lane_res[c])
        );
        assign res_all[c*DWIDTH +: DWIDTH] = lane_res[c];
    end

endmodule

// File: tb/tb_fc_data_mover.sv
// tb_fc_data_mover: randomized self-checking bench against a behavioural FC-layer model
module tb_fc_data_mover;
    localparam int CB = 31, DW = 32, AW = 12, MS = 4096, IW = 8, NC = 8;

    logic clk = 1'b0, reset = 1'b1, i_run = 1'b0, i_signed = 1'b0, i_relu = 1'b0;
    logic [CB-1:0] i_num_cnt = '0;
    logic o_idle, o_read, o_write, o_done, ce_node, ce_wgt, ce_bias, ce_res, we_res;
    logic [AW-1:0] addr_node, addr_wgt, addr_bias, addr_res;
    logic [DW-1:0] q_node = '0, d_res;
    logic [NC*DW-1:0] q_wgt = '0, q_bias = '0, o_result;
    logic [DW-1:0] node_mem [MS];
    logic [NC*DW-1:0] wgt_mem [MS];
    logic [NC*DW-1:0] bias_word;
    logic [DW-1:0] res_mem [NC];
    int checks = 0, failures = 0;

    fc_data_mover #(
        .CNT_BIT(CB), .DWIDTH(DW), .AWIDTH(AW), .MEM_SIZE(MS), .IN_DATA_WIDTH(IW), .NUM_CORE(NC)
    ) dut (
        .clk(clk), .reset(reset), .i_run(i_run), .i_num_cnt(i_num_cnt),
        .i_signed(i_signed), .i_relu(i_relu),
        .o_idle(o_idle), .o_read(o_read), .o_write(o_write), .o_done(o_done),
        .addr_node(addr_node), .ce_node(ce_node), .q_node(q_node),
        .addr_wgt(addr_wgt), .ce_wgt(ce_wgt), .q_wgt(q_wgt),
        .addr_bias(addr_bias), .ce_bias(ce_bias), .q_bias(q_bias),
        .addr_res(addr_res), .ce_res(ce_res), .we_res(we_res), .d_res(d_res),
        .o_result(o_result)
    );

    always #5 clk = ~clk;

    // BRAM bank: one-cycle read latency, result memory captures writes
    always @(posedge clk) begin
        if (ce_node) q_node <= node_mem[addr_node];
        if (ce_wgt) q_wgt <= wgt_mem[addr_wgt];
        if (ce_bias) q_bias <= bias_word;
        if (ce_res && we_res) res_mem[addr_res[2:0]] <= d_res;
    end

    task automatic chk(input string nm, input logic [NC*DW-1:0] act, input logic [NC*DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [DW-1:0] model_lane(input int c, input int n, input bit sgn, input bit relu);
        logic [DW-1:0] acc;
        logic [IW-1:0] nb, wb;
        int x, y;
        acc = bias_word[c*DW +: DW];
        for (int k = 0; k < n; k++)
            for (int e = 0; e < DW/IW; e++) begin
                nb = node_mem[k][DW-1-e*IW -: IW];
                wb = wgt_mem[k][c*DW + DW-1-e*IW -: IW];
                if (sgn) begin x = int'($signed(nb)); y = int'($signed(wb)); end
                else begin x = int'(nb); y = int'(wb); end
                acc = acc + DW'(x * y);
            end
        return (relu && sgn && acc[DW-1]) ? '0 : acc;
    endfunction

    task automatic fill(input int n);
        for (int k = 0; k < n; k++) begin
            node_mem[k] = $urandom;
            for (int c = 0; c < NC; c++) wgt_mem[k][c*DW +: DW] = $urandom;
        end
        for (int c = 0; c < NC; c++) bias_word[c*DW +: DW] = $urandom;
    endtask

    // starts at a negedge in IDLE, checks every cycle up to the first IDLE cycle after DONE
    task automatic run(input logic [CB-1:0] cnt, input bit sgn, input bit relu, input bit noise,
                       output int done_at, output int reads);
        int n, tot, c;
        bit rd, wr;
        logic [DW-1:0] er [NC];
        logic [NC*DW-1:0] ep;
        logic [88:0] act, exp;
        n = (cnt > CB'(MS)) ? MS : int'(cnt);
        for (int l = 0; l < NC; l++) begin
            er[l] = model_lane(l, n, sgn, relu);
            ep[l*DW +: DW] = er[l];
        end
        i_num_cnt = cnt; i_signed = sgn; i_relu = relu; i_run = 1'b1;
        tot = n + 5 + NC; done_at = -1; reads = 0;
        for (int t = 1; t <= tot; t++) begin
            @(negedge clk);
            rd = (t >= 2) && (t <= n + 1);
            wr = (t >= n + 4) && (t <= n + 3 + NC);
            c = wr ? t - n - 4 : 0;
            act = {o_idle, o_read, o_write, o_done, ce_node, ce_wgt, ce_bias, ce_res, we_res,
                   addr_node, addr_wgt, addr_bias, addr_res, d_res};
            exp = {t == tot, rd, wr, t == tot - 1, rd, rd, t == 1, wr, wr,
                   rd ? AW'(t - 2) : AW'(0), rd ? AW'(t - 2) : AW'(0), AW'(0),
                   wr ? AW'(c) : AW'(0), wr ? er[c] : DW'(0)};
            chk($sformatf("cyc%0d_n%0d", t, n), (NC*DW)'(act), (NC*DW)'(exp));
            if (o_done && done_at < 0) done_at = t;
            if (ce_node) reads++;
            if (noise && t < n + NC) begin
                i_run = 1'($urandom); i_num_cnt = CB'($urandom);
                i_signed = 1'($urandom); i_relu = 1'($urandom);
            end else i_run = 1'b0;
        end
        chk("o_result", o_result, ep);
        for (int l = 0; l < NC; l++) chk($sformatf("res_mem%0d", l), (NC*DW)'(res_mem[l]), (NC*DW)'(er[l]));
    endtask

    initial begin
        int da, rc;
        repeat (3) @(negedge clk);
        chk("rst_out", (NC*DW)'({o_idle, o_read, o_write, o_done, ce_node, ce_wgt, ce_bias, ce_res, we_res,
                                 addr_node, addr_wgt, addr_bias, addr_res, d_res}), (NC*DW)'({1'b1, 88'h0}));
        chk("rst_result", o_result, '0);
        reset = 1'b0;
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            node_mem[k] = 32'h01010101;
            for (int c = 0; c < NC; c++) wgt_mem[k][c*DW +: DW] = {4{8'(c + 1)}};
        end
        for (int c = 0; c < NC; c++) bias_word[c*DW +: DW] = 100;
        run(4, 1'b0, 1'b0, 1'b0, da, rc);
        chk("t1_done", (NC*DW)'(da), (NC*DW)'(16));
        for (int c = 0; c < NC; c++) chk("t1_lane", (NC*DW)'(o_result[c*DW +: DW]), (NC*DW)'(100 + 16 * (c + 1)));

        for (int c = 0; c < NC; c++) bias_word[c*DW +: DW] = DW'(c);
        run(0, 1'b0, 1'b0, 1'b0, da, rc);
        chk("n0_done", (NC*DW)'(da), (NC*DW)'(12));
        chk("n0_reads", (NC*DW)'(rc), '0);
        for (int c = 0; c < NC; c++) chk("n0_lane", (NC*DW)'(o_result[c*DW +: DW]), (NC*DW)'(c));

        for (int k = 0; k < 2; k++) begin
            node_mem[k] = 32'hFFFFFFFF;
            for (int c = 0; c < NC; c++) wgt_mem[k][c*DW +: DW] = 32'h02020202;
        end
        for (int c = 0; c < NC; c++) bias_word[c*DW +: DW] = 5;
        run(2, 1'b1, 1'b1, 1'b1, da, rc);
        chk("relu_on", (NC*DW)'(o_result[DW-1:0]), '0);
        run(2, 1'b1, 1'b0, 1'b0, da, rc);
        chk("relu_off", (NC*DW)'(o_result[DW-1:0]), (NC*DW)'(32'hFFFFFFF5));

        node_mem[0] = 32'hFFFFFFFF;
        wgt_mem[0] = '1;
        bias_word = '1;
        run(1, 1'b0, 1'b0, 1'b0, da, rc);
        chk("wrap", (NC*DW)'(o_result[3*DW +: DW]), (NC*DW)'(32'h0003F803));

        fill(16);
        i_num_cnt = 16; i_run = 1'b1;
        @(negedge clk);
        i_run = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_now", (NC*DW)'({o_idle, o_read, o_write, o_done, ce_node, ce_wgt, ce_bias, ce_res, we_res}),
            (NC*DW)'(9'h100));
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (i == 2) reset = 1'b0;
            chk("abort_hold", (NC*DW)'({o_idle, we_res, ce_res}), (NC*DW)'(3'b100));
        end
        fill(16);
        run(16, 1'b0, 1'b0, 1'b0, da, rc);

        for (int r = 0; r < 20; r++) begin
            int n;
            n = $urandom_range(0, 20);
            fill(n);
            run(CB'(n), 1'($urandom), 1'($urandom), 1'b1, da, rc);
        end

        fill(MS);
        run(CB'(MS + 5), 1'b1, 1'b0, 1'b1, da, rc);
        chk("clamp_reads", (NC*DW)'(rc), (NC*DW)'(MS));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
